// File: rtl/pll_dynport_pkg.sv
// PLL dynamic phase port types and constants.
// Shared by the request arbiter and the phase sequencer.
package pll_dynport_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STEP_HI,
    S_STEP_LO,
    S_LOAD,
    S_WAIT_LOCK,
    S_ACK
  } state_t;

  localparam logic [2:0] CLKOP  = 3'd0;
  localparam logic [2:0] CLKOS  = 3'd1;
  localparam logic [2:0] CLKOS2 = 3'd2;
  localparam logic [2:0] CLKOS3 = 3'd3;
  localparam logic [2:0] CLKOS4 = 3'd4;
  localparam logic [2:0] CLKOS5 = 3'd5;

  localparam logic DIR_LAG  = 1'b1;
  localparam logic DIR_LEAD = 1'b0;

  function automatic logic signed [15:0] sat16(
    input logic signed [31:0] v
  );
    if (v > 32'sd32767)
      return 16'sd32767;
    else if (v < -32'sd32767)
      return -16'sd32767;
    else
      return v[15:0];
  endfunction

endpackage

// File: rtl/pll_req_rr_arb.sv
// Round-robin grant over the phase-port requesters.
// Pointer advances past the owner only when its op is acked.
module pll_req_rr_arb
  import pll_dynport_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               take_i,
  input  logic               ack_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               any_o
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] own;
  int            c;

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    c     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = int'(ptr) + k;
      if (c >= NUM_REQ)
        c = c - NUM_REQ;
      if (!any_o && req_i[c]) begin
        any_o = 1'b1;
        idx_o = IW'(c);
      end
    end
    gnt_o = any_o ? (NUM_REQ'(1) << idx_o) : '0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ptr <= '0;
      own <= '0;
    end else begin
      if (take_i)
        own <= idx_o;
      if (ack_i)
        ptr <= (own == IW'(NUM_REQ - 1)) ? '0 : own + 1'b1;
    end
  end

endmodule

// File: rtl/pll_phase_req_arb.sv
// Runtime sequencer sharing the PLL dynamic phase port between requesters.
// Define PHASE_ARB_ACCUM_EN to add the per-output net step accumulator (acc_o).
module pll_phase_req_arb
  import pll_dynport_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int STEP_W    = 8,
  parameter int SETUP_CYC = 2,
  parameter int STEP_CYC  = 4,
  parameter int LOAD_CYC  = 2,
  parameter int LOCK_TMO  = 4096
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      done_pll_init_i,
  input  logic                      pll_lock_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*3-1:0]      req_sel_i,
  input  logic [NUM_REQ-1:0]        req_dir_i,
  input  logic [NUM_REQ*STEP_W-1:0] req_steps_i,
`ifdef PHASE_ARB_ACCUM_EN
  output logic [8*16-1:0]           acc_o,
`endif
  output logic [NUM_REQ-1:0]        ack_o,
  output logic                      busy_o,
  output logic                      err_o,
  output logic [2:0]                phasesel_o,
  output logic                      phasedir_o,
  output logic                      phasestep_o,
  output logic                      phaseloadreg_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW =
    $clog2(LOCK_TMO + SETUP_CYC + STEP_CYC + LOAD_CYC + 1);

  state_t               state;
  state_t               state_d;
  logic [TW-1:0]        tmr;
  logic [TW-1:0]        tmr_d;
  logic [STEP_W-1:0]    cnt;
  logic [STEP_W-1:0]    cnt_d;
  logic [STEP_W-1:0]    steps_sel;
  logic [2:0]           sel_q;
  logic                 dir_q;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [IW-1:0]        idx;
  logic                 any;
  logic                 take;
  logic                 err_d;
  logic                 lock_m;
  logic                 lock_s;
  logic                 drive;

  pll_req_rr_arb #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .req_i (req_i),
    .take_i(take),
    .ack_i (state == S_ACK),
    .gnt_o (gnt),
    .idx_o (idx),
    .any_o (any)
  );

  assign steps_sel = req_steps_i[int'(idx)*STEP_W +: STEP_W];

  assign drive = (state == S_SETUP)   || (state == S_STEP_HI) ||
                 (state == S_STEP_LO) || (state == S_LOAD)    ||
                 (state == S_WAIT_LOCK);

  always_comb begin
    state_d = state;
    tmr_d   = tmr + 1'b1;
    cnt_d   = cnt;
    err_d   = err_o;
    take    = 1'b0;
    unique case (state)
      S_IDLE: begin
        tmr_d = '0;
        // owner's req is still high while its ack pin is shown
        if (done_pll_init_i && any && ~|ack_o) begin
          take    = 1'b1;
          cnt_d   = steps_sel;
          state_d = (steps_sel == '0) ? S_ACK : S_SETUP;
        end
      end
      S_SETUP: begin
        if (tmr == TW'(SETUP_CYC - 1)) begin
          tmr_d   = '0;
          state_d = S_STEP_HI;
        end
      end
      S_STEP_HI: begin
        if (tmr == TW'(STEP_CYC - 1)) begin
          tmr_d   = '0;
          state_d = S_STEP_LO;
        end
      end
      S_STEP_LO: begin
        if (tmr == TW'(STEP_CYC - 1)) begin
          tmr_d   = '0;
          cnt_d   = cnt - 1'b1;
          state_d = (cnt == STEP_W'(1)) ? S_LOAD : S_STEP_HI;
        end
      end
      S_LOAD: begin
        if (tmr == TW'(LOAD_CYC - 1)) begin
          tmr_d   = '0;
          state_d = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        // first synced sample predates the load, so skip it
        if (tmr != '0 && lock_s) begin
          state_d = S_ACK;
        end else if (tmr == TW'(LOCK_TMO - 1)) begin
          err_d   = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        tmr_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        tmr_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state          <= S_IDLE;
      tmr            <= '0;
      cnt            <= '0;
      sel_q          <= CLKOP;
      dir_q          <= DIR_LEAD;
      gnt_q          <= '0;
      lock_m         <= 1'b0;
      lock_s         <= 1'b0;
      err_o          <= 1'b0;
      ack_o          <= '0;
      busy_o         <= 1'b0;
      phasesel_o     <= CLKOP;
      phasedir_o     <= DIR_LEAD;
      phasestep_o    <= 1'b0;
      phaseloadreg_o <= 1'b0;
    end else begin
      state  <= state_d;
      tmr    <= tmr_d;
      cnt    <= cnt_d;
      err_o  <= err_d;
      lock_m <= pll_lock_i;
      lock_s <= lock_m;
      if (take) begin
        sel_q <= req_sel_i[int'(idx)*3 +: 3];
        dir_q <= req_dir_i[idx];
        gnt_q <= gnt;
      end
      ack_o          <= (state == S_ACK) ? gnt_q : '0;
      busy_o         <= (state_d != S_IDLE) || (state == S_ACK);
      phasesel_o     <= drive ? sel_q : CLKOP;
      phasedir_o     <= drive ? dir_q : DIR_LEAD;
      phasestep_o    <= (state == S_STEP_HI);
      phaseloadreg_o <= (state == S_LOAD);
    end
  end

`ifdef PHASE_ARB_ACCUM_EN
  logic signed [15:0] acc [8];
  logic [STEP_W-1:0]  steps_q;
  logic signed [31:0] cur;
  logic signed [31:0] delta;

  always_comb begin
    cur   = acc[sel_q];
    delta = signed'(32'(steps_q));
    if (dir_q == DIR_LEAD)
      delta = -delta;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      steps_q <= '0;
      for (int i = 0; i < 8; i++)
        acc[i] <= '0;
    end else begin
      if (take)
        steps_q <= steps_sel;
      if (state == S_ACK)
        acc[sel_q] <= sat16(cur + delta);
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_acc
    assign acc_o[i*16 +: 16] = acc[i];
  end
`endif

endmodule

// File: tb/tb_pll_phase_req_arb.sv
// Bench for pll_phase_req_arb: per-cycle timeline model plus
// directed scenarios with hand-computed latencies.
module tb_pll_phase_req_arb;

  localparam int S    = 2;
  localparam int STEP = 4;
  localparam int L    = 2;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        done = 1'b0;
  logic        lock = 1'b1;
  logic [3:0]  req = '0;
  logic [11:0] sel_v = '0;
  logic [3:0]  dir_v = '0;
  logic [31:0] steps_v = '0;
  logic [3:0]  ack;
  logic        busy;
  logic        err;
  logic [2:0]  psel;
  logic        pdir;
  logic        pstep;
  logic        pload;
`ifdef PHASE_ARB_ACCUM_EN
  logic [127:0] acc;
`endif

  pll_phase_req_arb #(
    .NUM_REQ(4), .STEP_W(8), .SETUP_CYC(S),
    .STEP_CYC(STEP), .LOAD_CYC(L), .LOCK_TMO(TMO)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .done_pll_init_i(done),
    .pll_lock_i     (lock),
    .req_i          (req),
    .req_sel_i      (sel_v),
    .req_dir_i      (dir_v),
    .req_steps_i    (steps_v),
`ifdef PHASE_ARB_ACCUM_EN
    .acc_o          (acc),
`endif
    .ack_o          (ack),
    .busy_o         (busy),
    .err_o          (err),
    .phasesel_o     (psel),
    .phasedir_o     (pdir),
    .phasestep_o    (pstep),
    .phaseloadreg_o (pload)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit lock_hist [16384];

  // model of the operation in flight
  bit m_op, m_to, m_err;
  int m_g, m_n, m_sel, m_dir, m_own, m_ack, m_T, m_ptr;

  // observed events
  int step_rises, load_rises, multi_ack, last_ack_cyc;
  int ack_cnt [4];
  int ack_q [$];
  bit pstep_p, pload_p;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int i, input int s, input int d, input int n);
    sel_v[i*3 +: 3]   = 3'(s);
    dir_v[i]          = d[0];
    steps_v[i*8 +: 8] = 8'(n);
  endtask

  task automatic step_model();
    int t, o, o2, j;
    logic [3:0] ea;
    logic [2:0] es;
    logic eb, ee, ed, est, eld;
    lock_hist[cyc % 16384] = lock;
    if (!rstn) begin
      m_op = 0; m_to = 0; m_err = 0; m_ptr = 0;
      pstep_p = 0; pload_p = 0;
      return;
    end
    t = cyc;
    if (pstep && !pstep_p) step_rises++;
    if (pload && !pload_p) load_rises++;
    pstep_p = pstep;
    pload_p = pload;
    if (ack != 0) begin
      last_ack_cyc = t;
      if ($countones(ack) > 1) multi_ack++;
      for (int k = 0; k < 4; k++)
        if (ack[k]) begin
          ack_cnt[k]++;
          ack_q.push_back(k);
        end
    end
    if (m_op && m_n > 0 && m_ack < 0 && t - m_T >= 1) begin
      if (lock_hist[(t - 2) % 16384])
        m_ack = t + 2;
      else if (t - m_T == TMO - 1) begin
        m_ack = t + 2;
        m_to  = 1;
      end
    end
    if (m_op && m_ack >= 0 && t > m_ack) begin
      m_op  = 0;
      m_ptr = (m_own + 1) % 4;
      if (m_to) m_err = 1;
      m_to = 0;
    end
    ea = '0; eb = 0; ee = m_err; es = '0; ed = 0; est = 0; eld = 0;
    if (m_op) begin
      eb = (t >= m_g + 1) && (m_ack < 0 || t <= m_ack);
      if (t == m_ack) ea = 4'(1 << m_own);
      if (m_to && t >= m_ack - 1) ee = 1;
      if (m_n > 0 && t >= m_g + 2 && (m_ack < 0 || t <= m_ack - 1)) begin
        es = 3'(m_sel);
        ed = m_dir[0];
        o  = t - (m_g + 2 + S);
        if (o >= 0 && o < 2*STEP*m_n && (o % (2*STEP)) < STEP) est = 1;
        o2 = o - 2*STEP*m_n;
        if (o2 >= 0 && o2 < L) eld = 1;
      end
    end
    chk($sformatf("cycle%0d {ack,busy,err,sel,dir,step,load}", t),
        int'({ack, busy, err, psel, pdir, pstep, pload}),
        int'({ea, eb, ee, es, ed, est, eld}));
    if (!m_op && done && req != 0) begin
      for (int k = 3; k >= 0; k--) begin
        j = (m_ptr + k) % 4;
        if (req[j]) m_own = j;
      end
      m_op  = 1;
      m_to  = 0;
      m_g   = t;
      m_sel = int'(sel_v[m_own*3 +: 3]);
      m_dir = int'(dir_v[m_own]);
      m_n   = int'(steps_v[m_own*8 +: 8]);
      m_ack = (m_n == 0) ? t + 2 : -1;
      m_T   = t + 1 + S + 2*STEP*m_n + L;
    end
  endtask

  initial forever begin
    @(negedge clk);
    step_model();
  end

  task automatic serve(input string nm, input int budget);
    int n;
    logic [3:0] a;
    n = 0;
    while ((req != 0 || busy) && n < budget) begin
      @(negedge clk);
      a = ack;
      @(posedge clk);
      #1;
      req = req & ~a;
      n++;
    end
    chk({nm, "_within_budget"}, int'(n < budget), 1);
  endtask

  int d, r, st0, ld0, n;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_step", pstep, 0);
    chk("rst_sel", psel, 0);
    rstn = 1;

    // 1: blocked until init done, then 3 steps + load + ack
    set_req(0, 2, 1, 3);
    req = 4'b0001;
    repeat (10) @(posedge clk);
    #1;
    chk("nodone_busy", busy, 0);
    chk("nodone_steps", step_rises, 0);
    d = cyc; st0 = step_rises; ld0 = load_rises;
    done = 1;
    serve("t1", 200);
    chk("t1_steps", step_rises - st0, 3);
    chk("t1_loads", load_rises - ld0, 1);
    chk("t1_ack0_count", ack_cnt[0], 1);
    chk("t1_latency", last_ack_cyc - d, 32);

    // 5: async reset in the middle of a step pulse
    set_req(2, 5, 1, 2);
    req = 4'b0100;
    n = 0;
    while (!pstep && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_step", pstep, 1);
    #2 rstn = 0;
    #1;
    chk("t5_rst_step", pstep, 0);
    chk("t5_rst_sel", psel, 0);
    chk("t5_rst_dir", pdir, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_load", pload, 0);
    req = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;

    // 2: simultaneous requests, pointer back at 0
    set_req(0, 1, 0, 1);
    set_req(1, 3, 1, 1);
    set_req(3, 4, 1, 2);
    ack_q.delete();
    multi_ack = 0;
    req = 4'b1011;
    serve("t2", 400);
    chk("t2_ack_total", ack_q.size(), 3);
    chk("t2_first", ack_q.size() > 0 ? ack_q[0] : -1, 0);
    chk("t2_second", ack_q.size() > 1 ? ack_q[1] : -1, 1);
    chk("t2_third", ack_q.size() > 2 ? ack_q[2] : -1, 3);
    chk("t2_multi_ack", multi_ack, 0);

    // 3: zero steps never touches the port
    set_req(2, 6, 1, 0);
    st0 = step_rises; ld0 = load_rises; r = cyc;
    req = 4'b0100;
    serve("t3", 50);
    chk("t3_latency", last_ack_cyc - r, 2);
    chk("t3_steps", step_rises - st0, 0);
    chk("t3_loads", load_rises - ld0, 0);
    chk("t3_ack2_count", ack_cnt[2], 1);

    // 4: lock timeout sets sticky error
    lock = 0;
    set_req(1, 3, 0, 1);
    r = cyc;
    req = 4'b0010;
    serve("t4", 300);
    chk("t4_latency", last_ack_cyc - r, 13 + TMO + 1);
    chk("t4_err", err, 1);
    lock = 1;
    repeat (4) @(posedge clk);
    #1;
    set_req(0, 1, 1, 1);
    r = cyc;
    req = 4'b0001;
    serve("t4b", 100);
    chk("t4b_latency", last_ack_cyc - r, 1 + S + 2*STEP + L + 3);
    chk("t4b_err_sticky", err, 1);

`ifdef PHASE_ARB_ACCUM_EN
    // 6: net step accumulation on output 1
    rstn = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    set_req(1, 1, 1, 5);
    req = 4'b0010;
    serve("t6a", 200);
    set_req(1, 1, 0, 2);
    req = 4'b0010;
    serve("t6b", 200);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t6_acc%0d", i),
          int'($signed(acc[i*16 +: 16])), (i == 1) ? 3 : 0);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
